// File: rtl/clk_freq_meter.sv
// clk_freq_meter: counts rising edges of CLK_MEAS over a gate window of
// GATE_CYCLES clk_4m cycles and latches the count into RESULT/OVF.
// Optional range check is built when FREQ_RANGE_CHECK_EN is defined
// (adds EXP_MIN, EXP_MAX, IN_RANGE).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for START, RESULT/OVF hold the last measurement
// GATE  | gate window open, edges counted, gate down-counter running
// LATCH | one-cycle DONE pulse, RESULT/OVF already carry the new count

module clk_freq_meter #(
    parameter int GATE_CYCLES = 40000,
    parameter int COUNT_W     = 16,
    parameter int GATE_W      = 16
) (
    input  logic               clk_4m,
    input  logic               RST_B,
    input  logic               CLK_MEAS,
    input  logic               START,
`ifdef FREQ_RANGE_CHECK_EN
    input  logic [COUNT_W-1:0] EXP_MIN,
    input  logic [COUNT_W-1:0] EXP_MAX,
    output logic               IN_RANGE,
`endif
    output logic               BUSY,
    output logic               DONE,
    output logic [COUNT_W-1:0] RESULT,
    output logic               OVF
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GATE  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);

    logic [1:0]         state;
    logic               sync1, sync2, sync3;
    logic               edge_det;
    logic [COUNT_W-1:0] edge_cnt;
    logic [COUNT_W-1:0] edge_cnt_nxt;
    logic               ovf_int;
    logic               ovf_nxt;
    logic [GATE_W-1:0]  gate_cnt;
    logic               gate_last;

    assign edge_det  = sync2 & ~sync3;
    assign gate_last = (gate_cnt == '0);
    assign BUSY      = (state == GATE);
    assign DONE      = (state == LATCH);

    // CLK_MEAS synchronizer plus edge-detect flop, free-running in all states
    always_ff @(posedge clk_4m or negedge RST_B) begin
        if (!RST_B) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= CLK_MEAS;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Saturating next count: an edge on a full counter only raises ovf
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        ovf_nxt      = ovf_int;
        if (edge_det) begin
            if (&edge_cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt + COUNT_W'(1);
            end
        end
    end

    // Sequencer, gate down-counter and edge counter
    always_ff @(posedge clk_4m or negedge RST_B) begin
        if (!RST_B) begin
            state    <= IDLE;
            edge_cnt <= '0;
            ovf_int  <= 1'b0;
            gate_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        edge_cnt <= '0;
                        ovf_int  <= 1'b0;
                        gate_cnt <= GATE_LOAD;
                        state    <= GATE;
                    end
                end
                GATE: begin
                    edge_cnt <= edge_cnt_nxt;
                    ovf_int  <= ovf_nxt;
                    gate_cnt <= gate_cnt - GATE_W'(1);
                    if (gate_last) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result capture on the closing gate cycle so it is valid while DONE is high
    always_ff @(posedge clk_4m or negedge RST_B) begin
        if (!RST_B) begin
            RESULT <= '0;
            OVF    <= 1'b0;
        end else if (state == GATE && gate_last) begin
            RESULT <= edge_cnt_nxt;
            OVF    <= ovf_nxt;
        end
    end

`ifdef FREQ_RANGE_CHECK_EN
    // Range verdict captured together with RESULT
    always_ff @(posedge clk_4m or negedge RST_B) begin
        if (!RST_B) begin
            IN_RANGE <= 1'b0;
        end else if (state == GATE && gate_last) begin
            IN_RANGE <= ~ovf_nxt & (edge_cnt_nxt >= EXP_MIN) & (edge_cnt_nxt <= EXP_MAX);
        end
    end
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with a short gate window (800 cycles =
// 200 us) and a 7-bit counter so saturation is reachable at 1 MHz.
`timescale 1ns/1ps

module tb_clk_freq_meter;

    localparam int GATE    = 800;
    localparam int COUNT_W = 7;
    localparam int GATE_W  = 12;

    logic               clk_4m;
    logic               RST_B;
    logic               CLK_MEAS;
    logic               START;
    logic               BUSY;
    logic               DONE;
    logic [COUNT_W-1:0] RESULT;
    logic               OVF;
`ifdef FREQ_RANGE_CHECK_EN
    logic [COUNT_W-1:0] exp_min;
    logic [COUNT_W-1:0] exp_max;
    logic               in_range;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int meas_half   = 0;
    logic meas_static = 1'b0;

    clk_freq_meter #(
        .GATE_CYCLES(GATE),
        .COUNT_W    (COUNT_W),
        .GATE_W     (GATE_W)
    ) dut (
        .clk_4m  (clk_4m),
        .RST_B   (RST_B),
        .CLK_MEAS(CLK_MEAS),
        .START   (START),
`ifdef FREQ_RANGE_CHECK_EN
        .EXP_MIN (exp_min),
        .EXP_MAX (exp_max),
        .IN_RANGE(in_range),
`endif
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RESULT  (RESULT),
        .OVF     (OVF)
    );

    initial clk_4m = 1'b0;
    always #125 clk_4m = ~clk_4m;

    // Measured clock: toggle times stay 13 ns off the 125 ns grid
    initial begin
        CLK_MEAS = 1'b0;
        #13;
        forever begin
            if (meas_half == 0) begin
                CLK_MEAS = meas_static;
                #125;
            end else begin
                #(meas_half) CLK_MEAS = ~CLK_MEAS;
            end
        end
    end

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got < exp - tol || got > exp + tol) begin
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_meas(input int half, input logic lvl);
        meas_half   = half;
        meas_static = lvl;
        repeat (60) @(posedge clk_4m);
        #1;
    endtask

    task automatic run_meas(input string tag, input int exp_cnt, input int tol,
                            input int exp_ovf, input bit repulse);
        int n;
        int extra_done;
        @(posedge clk_4m); #1 START = 1'b1;
        @(posedge clk_4m); #1 START = 1'b0;
        check_val({tag, "_busy_rise"}, BUSY, 1, 0);
        n = 0;
        while (BUSY && n < 4 * GATE) begin
            START = repulse && (n == 5 || n == GATE / 2);
            @(posedge clk_4m); #1;
            n++;
        end
        START = 1'b0;
        check_val({tag, "_busy_len"}, n, GATE, 0);
        check_val({tag, "_done"}, DONE, 1, 0);
        check_val({tag, "_result"}, RESULT, exp_cnt, tol);
        check_val({tag, "_ovf"}, OVF, exp_ovf, 0);
        START = 1'b1;
        @(posedge clk_4m); #1 START = 1'b0;
        check_val({tag, "_done_fall"}, DONE, 0, 0);
        check_val({tag, "_latch_start_ignored"}, BUSY, 0, 0);
        if (repulse) begin
            extra_done = 0;
            repeat (40) begin
                @(posedge clk_4m); #1;
                if (DONE) extra_done++;
            end
            check_val({tag, "_extra_done"}, extra_done, 0, 0);
            check_val({tag, "_result_hold"}, RESULT, exp_cnt, tol);
        end
    endtask

    initial begin
        int done_seen;
        int busy_seen;
        RST_B = 1'b0;
        START = 1'b0;
`ifdef FREQ_RANGE_CHECK_EN
        exp_min = 7'd19;
        exp_max = 7'd21;
`endif
        repeat (3) @(posedge clk_4m);
        #1;
        check_val("rst_busy", BUSY, 0, 0);
        check_val("rst_done", DONE, 0, 0);
        check_val("rst_result", RESULT, 0, 0);
        check_val("rst_ovf", OVF, 0, 0);
`ifdef FREQ_RANGE_CHECK_EN
        check_val("rst_in_range", in_range, 0, 0);
`endif
        #50 RST_B = 1'b1;

        // 100 kHz: 40-cycle period over 800 cycles -> 20 edges
        set_meas(5000, 1'b0);
        run_meas("f100k", 20, 1, 0, 1'b0);
`ifdef FREQ_RANGE_CHECK_EN
        check_val("f100k_in_range", in_range, 1, 0);
`endif

        // 1 MHz: 200 edges saturate the 7-bit counter
        set_meas(500, 1'b0);
        run_meas("f1m_sat", 127, 0, 1, 1'b0);
`ifdef FREQ_RANGE_CHECK_EN
        check_val("f1m_in_range", in_range, 0, 0);
`endif

        // 500 kHz: 100 edges, overflow clears
        set_meas(1000, 1'b0);
        run_meas("f500k", 100, 1, 0, 1'b0);

        set_meas(0, 1'b0);
        run_meas("static_lo", 0, 0, 0, 1'b0);
        set_meas(0, 1'b1);
        run_meas("static_hi", 0, 0, 0, 1'b0);

        // 50 kHz: 10 edges
        set_meas(10000, 1'b0);
        run_meas("f50k", 10, 1, 0, 1'b0);
`ifdef FREQ_RANGE_CHECK_EN
        check_val("f50k_in_range", in_range, 0, 0);
`endif

        // START re-pulsed mid-window must not restart or queue
        set_meas(5000, 1'b0);
        run_meas("repulse", 20, 1, 0, 1'b1);

        // Reset halfway through a window
        @(posedge clk_4m); #1 START = 1'b1;
        @(posedge clk_4m); #1 START = 1'b0;
        repeat (GATE / 2) @(posedge clk_4m);
        #51 RST_B = 1'b0;
        #1;
        check_val("abort_busy", BUSY, 0, 0);
        check_val("abort_done", DONE, 0, 0);
        check_val("abort_result", RESULT, 0, 0);
        check_val("abort_ovf", OVF, 0, 0);
        #100 RST_B = 1'b1;
        done_seen = 0;
        busy_seen = 0;
        repeat (2 * GATE) begin
            @(posedge clk_4m); #1;
            if (DONE) done_seen++;
            if (BUSY) busy_seen++;
        end
        check_val("abort_no_done", done_seen, 0, 0);
        check_val("abort_no_busy", busy_seen, 0, 0);

        run_meas("post_rst", 20, 1, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
